// File: rtl/produto_bcd_display.sv
// -----------------------------------------------------------------------------
// produto_bcd_display
//
// Purpose:
//   Final stage after the 5x5 array multiplier. The 10-bit unsigned product is
//   converted to decimal with a sequential shift-and-add-3 (double dabble)
//   engine, one bit per clock. The result is driven on a registered BCD bus and
//   on active-low 7-segment digits (DE2 HEX displays). A start/busy/done
//   handshake lets a controller request a refresh. Tying start high gives a
//   continuously refreshed display.
//
// Parameters:
//   IN_W          binary input width (product width)
//   DIGITS        BCD digits produced; 10**DIGITS must exceed 2**IN_W
//   BLANK_LEADING 1 = blank leading-zero digits above digit 0, 0 = show all
//
// Ports:
//   CLOCK_50  in   1          single clock, all state changes on rising edge
//   rst_n     in   1          asynchronous active-low reset
//   bin_in    in   IN_W       unsigned binary value to convert
//   start     in   1          conversion request, sampled only in IDLE
//   busy      out  1          conversion in progress (CONV and DONE states)
//   done      out  1          one-cycle pulse: bcd_out/HEX_OUT just updated
//   bcd_out   out  4*DIGITS   registered result, digit n at [4n+3:4n]
//   HEX_OUT   out  7*DIGITS   active-low segments, digit n at [7n+6:7n], gfedcba
// -----------------------------------------------------------------------------
module produto_bcd_display #(
    parameter int IN_W          = 10,
    parameter int DIGITS        = 4,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  rst_n,
    input  logic [IN_W-1:0]       bin_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [7*DIGITS-1:0]   HEX_OUT
);

    localparam int CNT_W = $clog2(IN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    state_t               r_state;
    logic [IN_W-1:0]      r_shift;
    logic [4*DIGITS-1:0]  r_scratch;
    logic [CNT_W-1:0]     r_count;
    logic                 r_busy;
    logic                 r_done;
    logic [4*DIGITS-1:0]  r_bcd;

    logic [4*DIGITS-1:0]  w_adj;
    logic [7*DIGITS-1:0]  w_hex;

    // Add-3 correction applied to every scratch digit before the shift, so a
    // digit that would reach 10 or more after doubling carries into the next.
    // NOTE: every combinational output gets a default before any conditional
    // update; without it the tool infers a latch for the untouched paths.
    always_comb begin
        w_adj = r_scratch;
        for (int n = 0; n < DIGITS; n++) begin
            if (r_scratch[4*n +: 4] >= 4'd5) begin
                w_adj[4*n +: 4] = r_scratch[4*n +: 4] + 4'd3;
            end
        end
    end

    // Control FSM and datapath in one block; all outputs are registered.
    // NOTE: the reset is asynchronous, so it sits in the sensitivity list and
    // takes effect without a clock edge, which also aborts a conversion.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift   <= bin_in;
                        r_scratch <= '0;
                        r_count   <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_CONV;
                    end
                end
                S_CONV: begin
                    // MSB of the binary shift register enters scratch bit 0.
                    r_scratch <= {w_adj[4*DIGITS-2:0], r_shift[IN_W-1]};
                    r_shift   <= {r_shift[IN_W-2:0], 1'b0};
                    r_count   <= r_count + 1'b1;
                    if (r_count == CNT_W'(IN_W - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_bcd   <= r_scratch;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Active-low gfedcba decode; codes 10..15 cannot occur and show blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Walk from the most significant digit down; a digit above digit 0 is
    // blanked while it and everything above it are zero.
    always_comb begin
        logic v_zero_above;
        v_zero_above = 1'b1;
        w_hex        = '1;
        for (int n = DIGITS - 1; n >= 0; n--) begin
            v_zero_above = v_zero_above & (r_bcd[4*n +: 4] == 4'd0);
            if ((BLANK_LEADING != 0) && (n > 0) && v_zero_above) begin
                w_hex[7*n +: 7] = SEG_BLANK;
            end else begin
                w_hex[7*n +: 7] = seg7(r_bcd[4*n +: 4]);
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bcd_out = r_bcd;
    assign HEX_OUT = w_hex;

endmodule

// File: tb/tb_produto_bcd_display.sv
// -----------------------------------------------------------------------------
// tb_produto_bcd_display
//
// Directed bench for produto_bcd_display. Two instances share all inputs: one
// with leading-zero blanking, one without. Expected values are hand-computed
// BCD words and 7-segment patterns.
// -----------------------------------------------------------------------------
module tb_produto_bcd_display;

    localparam int IN_W   = 10;
    localparam int DIGITS = 4;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G6 = 7'b0000010;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GB = 7'b1111111;

    logic                 CLOCK_50;
    logic                 rst_n;
    logic [IN_W-1:0]      bin_in;
    logic                 start;
    logic                 busy,    busy_nb;
    logic                 done,    done_nb;
    logic [4*DIGITS-1:0]  bcd_out, bcd_nb;
    logic [7*DIGITS-1:0]  hex_out, hex_nb;

    int checks   = 0;
    int failures = 0;

    produto_bcd_display #(.IN_W(IN_W), .DIGITS(DIGITS), .BLANK_LEADING(1)) dut (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .bin_in   (bin_in),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .HEX_OUT  (hex_out)
    );

    produto_bcd_display #(.IN_W(IN_W), .DIGITS(DIGITS), .BLANK_LEADING(0)) dut_nb (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .bin_in   (bin_in),
        .start    (start),
        .busy     (busy_nb),
        .done     (done_nb),
        .bcd_out  (bcd_nb),
        .HEX_OUT  (hex_nb)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Pulse start for one edge, wait (bounded) for done, check the result.
    task automatic run_conv(input string tag, input logic [IN_W-1:0] value,
                            input logic [15:0] exp_bcd, input logic [27:0] exp_hex);
        int cycles;
        bin_in = value;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check({tag, "_busy_accept"}, busy, 1);
        cycles = 0;
        while (!done && cycles < 20) begin
            tick();
            cycles++;
        end
        check({tag, "_latency"}, cycles, 11);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_bcd"}, bcd_out, exp_bcd);
        check({tag, "_hex"}, hex_out, exp_hex);
        tick();
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int ndone;

        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        #12;
        // 1: reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bcd",  bcd_out, 16'h0000);
        check("rst_hex",  hex_out, {GB, GB, GB, G0});
        check("rst_hex_nb", hex_nb, {G0, G0, G0, G0});
        tick();
        rst_n = 1'b1;
        tick();

        // 2: 31*31 = 961
        run_conv("c961", 10'd961, 16'h0961, {GB, G9, G6, G1});

        // 3: boundaries
        run_conv("c0",    10'd0,    16'h0000, {GB, GB, GB, G0});
        run_conv("c1023", 10'd1023, 16'h1023, {G1, G0, G2, G3});

        // 4: bin_in change and start re-pulse during conversion are ignored
        bin_in = 10'd100;
        start  = 1'b1;
        tick();                          // E0
        start  = 1'b0;
        tick();                          // E0+1
        tick();                          // E0+2
        bin_in = 10'd555;
        tick();                          // E0+3
        tick();                          // E0+4
        start  = 1'b1;
        tick();                          // E0+5
        start  = 1'b0;
        check("hold_prev_bcd", bcd_out, 16'h1023);
        repeat (5) tick();               // E0+10
        check("t4_not_done_yet", done, 0);
        tick();                          // E0+11
        check("t4_done", done, 1);
        check("t4_bcd", bcd_out, 16'h0100);
        ndone = 0;
        repeat (15) begin
            tick();
            if (done) ndone++;
        end
        check("t4_single_done", ndone, 0);
        check("t4_idle", busy, 0);

        // 5: start held high, back-to-back every 12 cycles
        bin_in = 10'd500;
        start  = 1'b1;
        tick();                          // first accept
        for (int k = 0; k < 3; k++) begin
            repeat (10) tick();
            check("t5_no_early_done", done, 0);
            tick();
            check("t5_done", done, 1);
            check("t5_bcd", bcd_out, 16'h0500);
            check("t5_hex", hex_out, {GB, G5, G0, G0});
            check("t5_hex_nb", hex_nb, {G0, G5, G0, G0});
            tick();                      // re-accept while start high
            check("t5_reaccept_busy", busy, 1);
            check("t5_done_clear", done, 0);
        end
        start = 1'b0;
        repeat (12) tick();

        // 6: reset mid-conversion
        run_conv("c961b", 10'd961, 16'h0961, {GB, G9, G6, G1});
        bin_in = 10'd25;
        start  = 1'b1;
        tick();                          // E0
        start  = 1'b0;
        repeat (5) tick();               // E0+5
        rst_n = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_bcd", bcd_out, 16'h0000);
        check("t6_hex", hex_out, {GB, GB, GB, G0});
        ndone = 0;
        repeat (8) begin
            tick();
            if (done) ndone++;
        end
        check("t6_no_done", ndone, 0);
        rst_n = 1'b1;
        tick();
        run_conv("c25", 10'd25, 16'h0025, {GB, GB, G2, G5});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
